// File: rtl/hex_scan_mux.sv
// Time-multiplexed scanner for a 4-digit 7-segment display: snapshots a 16-bit
// hex value per frame, drives one active-low anode at a time with guard blanking.
module hex_scan_mux #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [3:0]  x,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_n;
  logic [1:0]    dig, dig_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   snap, snap_n;
  logic [3:0]    snap_dp, snap_dp_n;
  logic [3:0]    an_n, x_n;
  logic          dp_n, fd_n;
  logic          lz_blank;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= BLANK;
      dig        <= '0;
      cnt        <= '0;
      snap       <= '0;
      snap_dp    <= '0;
      an         <= '1;
      x          <= '0;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      dig        <= dig_n;
      cnt        <= cnt_n;
      snap       <= snap_n;
      snap_dp    <= snap_dp_n;
      an         <= an_n;
      x          <= x_n;
      dp         <= dp_n;
      frame_done <= fd_n;
    end
  end

  always_comb begin
    state_n   = state;
    dig_n     = dig;
    cnt_n     = cnt;
    snap_n    = snap;
    snap_dp_n = snap_dp;
    fd_n      = 1'b0;

    if (!en) begin
      state_n = BLANK;
      dig_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
            if (dig == 2'd0) begin
              snap_n    = value;
              snap_dp_n = dp_in;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            dig_n   = dig + 2'd1;
            fd_n    = (dig == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = BLANK;
      endcase
    end

    // Outputs are derived from the next state so they register on the entering edge.
    lz_blank = lzb && (dig_n != 2'd0) && ((snap_n >> {dig_n, 2'b00}) == '0);
    x_n      = snap_n[{dig_n, 2'b00} +: 4];
    an_n     = '1;
    dp_n     = 1'b1;
    if (state_n == SHOW && !lz_blank) begin
      an_n = ~(4'b0001 << dig_n);
      dp_n = ~snap_dp_n[dig_n];
    end
  end

endmodule

// File: tb/tb_hex_scan_mux.sv
// Self-checking bench for hex_scan_mux: a position-based reference model pushes
// expected outputs to a scoreboard queue each edge; samples are popped and compared.
module tb_hex_scan_mux;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  an;
  logic [3:0]  x;
  logic        dp;
  logic        frame_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [3:0] an;
    logic [3:0] x;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  // model state: edges since scanning (re)started, and the model's own snapshot
  int unsigned k      = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_sdp  = '0;

  hex_scan_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .value      (value),
    .dp_in      (dp_in),
    .lzb        (lzb),
    .an         (an),
    .x          (x),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Digit period 6 (2 blank + 4 show), frame 24 edges; snapshot on the edge entering digit 0.
  task automatic model_step();
    exp_t e;
    int unsigned ph, d, w;
    logic blank_lz;
    if (clr) begin
      k = 0; m_snap = '0; m_sdp = '0;
      e = '{an: 4'hF, x: 4'h0, dp: 1'b1, fd: 1'b0};
    end else if (!en) begin
      k = 0;
      e = '{an: 4'hF, x: m_snap[3:0], dp: 1'b1, fd: 1'b0};
    end else begin
      k++;
      ph = k % 24;
      w  = k % 6;
      d  = (k / 6) % 4;
      if (ph == 2) begin
        m_snap = value;
        m_sdp  = dp_in;
      end
      e.x = 4'((m_snap >> (4 * d)) & 16'hF);
      if (w < 2) begin
        e.an = 4'hF; e.dp = 1'b1; e.fd = (ph == 0);
      end else begin
        blank_lz = lzb && (d != 0) && ((m_snap >> (4 * d)) == 16'h0);
        e.fd = 1'b0;
        if (blank_lz) begin
          e.an = 4'hF; e.dp = 1'b1;
        end else begin
          e.an = ~(4'b0001 << d);
          e.dp = ~m_sdp[d];
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    e = sb.pop_front();
    check_eq("an", {12'h0, an}, {12'h0, e.an});
    check_eq("x", {12'h0, x}, {12'h0, e.x});
    check_eq("dp", {15'h0, dp}, {15'h0, e.dp});
    check_eq("frame_done", {15'h0, frame_done}, {15'h0, e.fd});
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // advance until the model sits at frame position ph (bounded)
  task automatic run_until(input int unsigned ph);
    int unsigned guard = 0;
    while ((k % 24) != ph && guard < 48) begin
      tick();
      guard++;
    end
    if ((k % 24) != ph) check_eq("sync_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; value = 16'h0; dp_in = 4'h0; lzb = 1'b0;
    #1;
    check_eq("rst_an", {12'h0, an}, 16'h000F);
    check_eq("rst_x", {12'h0, x}, 16'h0000);
    check_eq("rst_dp", {15'h0, dp}, 16'h0001);
    check_eq("rst_fd", {15'h0, frame_done}, 16'h0000);
    #11;
    clr = 1'b0;
    @(posedge clk); #1;

    // scan order and frame_done spacing
    en = 1'b1; value = 16'h1234;
    run(52);

    // snapshot: change value during digit 1 show
    run_until(8);
    value = 16'hABCD;
    run(40);

    // leading-zero blanking
    lzb = 1'b1; value = 16'h0050;
    run(30);
    value = 16'h0000;
    run(30);

    // decimal point on digit 2
    lzb = 1'b0; value = 16'h1234; dp_in = 4'b0100;
    run(30);

    // enable drop during digit 2 show, then restart with fresh snapshot
    dp_in = 4'h0;
    run_until(14);
    en = 1'b0;
    run(10);
    en = 1'b1; value = 16'h5678;
    run(30);

    // asynchronous clear mid-show, no clock edge
    run_until(15);
    #3;
    clr = 1'b1;
    #1;
    check_eq("aclr_an", {12'h0, an}, 16'h000F);
    check_eq("aclr_x", {12'h0, x}, 16'h0000);
    check_eq("aclr_dp", {15'h0, dp}, 16'h0001);
    check_eq("aclr_fd", {15'h0, frame_done}, 16'h0000);
    run(2);
    clr = 1'b0; value = 16'h9E07;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
